writer: RTL and testbench
=========================

WRITER -- requirements
Module: writer

Interface
REQ-001 Parameter NDWORDS, default 9, number of 32-bit dwords per array element.
REQ-002 Parameter FIFO_DEPTH, default 2, number of queued write requests (power of 2, >=2).
REQ-003 Derived constant ELEMSZ = 32*NDWORDS, element width in bits.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 baseaddr  in  32  byte address of array element 0; constant during operation.
REQ-007 index  in  32  element index of the write request.
REQ-008 data  in  ELEMSZ  element payload; dword k = data[32k+31:32k].
REQ-009 write  in  1  request valid; a request is accepted on a cycle with write && iready.
REQ-010 iready  out  1  request FIFO not full.
REQ-011 wdone  out  1  one-cycle pulse: an element has been fully written to SDRAM.
REQ-012 widx  out  32  index of the element completed; valid when wdone is high.
REQ-013 idle  out  1  FIFO empty and FSM in IDLE.
REQ-014 avm_m0_write / avm_m0_address[31:0] / avm_m0_writedata[15:0] / avm_m0_byteenable[1:0]  out  Avalon-MM write master.
REQ-015 avm_m0_read  out  1  tied 0; avm_m0_readdata[15:0] and avm_m0_readdatavalid are inputs and are ignored.
REQ-016 avm_m0_waitrequest  in  1  slave stall.

Function
REQ-017 Accepted requests SHALL be stored as {index, data} in a FIFO_DEPTH-entry FIFO, in order.
REQ-018 iready SHALL be !full of the current registered state; a pop in the same cycle does not raise iready.
REQ-019 FSM states SHALL be IDLE, WRITE, DONE.
REQ-020 IDLE: if FIFO is non-empty, pop the head into an element shift register and an index register, clear the beat counter, go to WRITE; otherwise stay.
REQ-021 WRITE: avm_m0_write=1; beat k (0..2*NDWORDS-1) SHALL drive address = baseaddr + 4*NDWORDS*idx + 2*k (mod 2^32) and writedata = halfword k of the element (k even: low half of dword k/2; odd: high half).
REQ-022 Beat advances only on a cycle where avm_m0_write && !avm_m0_waitrequest; address, writedata and write SHALL be held stable while waitrequest is high.
REQ-023 After beat 2*NDWORDS-1 is accepted, go to DONE.
REQ-024 DONE: wdone=1 and widx=stored index for exactly one cycle, avm_m0_write=0, then IDLE.
REQ-025 avm_m0_byteenable SHALL be 2'b11 whenever avm_m0_write is high.
REQ-026 Latency: a request accepted at edge E0 into an empty FIFO with FSM in IDLE drives beat 0 from edge E1; with waitrequest low, wdone is high in the cycle after edge E(2*NDWORDS+1). Back-to-back throughput is one element per 2*NDWORDS+2 cycles.
REQ-027 A push and a pop in the same cycle SHALL both take effect; occupancy stays unchanged.
REQ-028 The address multiply SHALL be computed at 32 bits and truncated; overflow wraps silently.
REQ-029 widx and the address registers SHALL be unaffected by new requests accepted during WRITE.

Reset
REQ-030 On reset assertion, all outputs SHALL go to these values immediately (asynchronously): avm_m0_write=0, avm_m0_address=0, avm_m0_writedata=0, wdone=0, widx=0, iready=1, idle=1.
REQ-031 Reset mid-burst SHALL abandon the element (no wdone pulse), empty the FIFO, and return the FSM to IDLE.

Structure
REQ-032 The FSM state enum and the halfword-per-element constant SHALL be defined in a shared package, together with the reader states.
REQ-033 The request queue SHALL be a sub-module named elem_fifo, parameterised by width and depth, with push/pop/full/empty ports.

Verification (NDWORDS=9, baseaddr=0x1000)
REQ-034 Single write: index=2, dword0=0xDEADBEEF, no waitrequest -> 18 beats at addresses 0x1048..0x106A step 2; beat0 writedata=0xBEEF, beat1=0xDEAD; wdone with widx=2 in the cycle after edge E19.
REQ-035 Stall: waitrequest high for 3 cycles on beat 5 -> address 0x1052 and its data are held for 4 cycles; total 18 accepted beats; wdone is 3 cycles later than in REQ-034.
REQ-036 Backpressure: 3 back-to-back requests (idx 0,1,2) with waitrequest held high -> iready low after the 3rd accept; on release, elements are written in order 0,1,2 with 3 wdone pulses.
REQ-037 Wrap: baseaddr=0xFFFFFFF0, index=0 -> beat 8 address=0x00000000.
REQ-038 Reset at beat 7 -> write=0 immediately; no wdone; idle=1 and iready=1 after release; a new request then completes normally.

Source files
------------

// File: rtl/writer_pkg.sv
// Shared types and constants for the SDRAM element writer and its companion reader.
package writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_READ,
    R_DONE
  } rd_state_t;

  // The SDRAM port is 16 bits wide, so each 32-bit dword takes two beats.
  localparam int HW_PER_DWORD = 2;

  function automatic int hw_per_elem(input int ndwords);
    return HW_PER_DWORD * ndwords;
  endfunction

endpackage

// File: rtl/writer_if.sv
// Avalon-MM master port bundle used by the element writer.
interface writer_if;
  import writer_pkg::*;

  logic        avm_m0_write;
  logic        avm_m0_read;
  logic [31:0] avm_m0_address;
  logic [15:0] avm_m0_writedata;
  logic [1:0]  avm_m0_byteenable;
  logic [15:0] avm_m0_readdata;
  logic        avm_m0_readdatavalid;
  logic        avm_m0_waitrequest;

  modport master (
    output avm_m0_write, avm_m0_read, avm_m0_address, avm_m0_writedata, avm_m0_byteenable,
    input  avm_m0_readdata, avm_m0_readdatavalid, avm_m0_waitrequest
  );

  modport slave (
    input  avm_m0_write, avm_m0_read, avm_m0_address, avm_m0_writedata, avm_m0_byteenable,
    output avm_m0_readdata, avm_m0_readdatavalid, avm_m0_waitrequest
  );

endinterface

// File: rtl/writer_elem_fifo.sv
// Small in-order request queue; storage is left unreset, only pointers and count reset.
module elem_fifo
  import writer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/writer.sv
// Queues {index, element} write requests and bursts each element to SDRAM as 16-bit beats.
module writer
  import writer_pkg::*;
#(
  parameter  int NDWORDS    = 9,
  parameter  int FIFO_DEPTH = 2,
  localparam int ELEMSZ     = 32 * NDWORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       baseaddr,
  input  logic [31:0]       index,
  input  logic [ELEMSZ-1:0] data,
  input  logic              write,
  output logic              iready,
  output logic              wdone,
  output logic [31:0]       widx,
  output logic              idle,
  writer_if.master          avm
);

  localparam int          NBEATS = hw_per_elem(NDWORDS);
  localparam int          BW     = $clog2(NBEATS);
  localparam int          QW     = 32 + ELEMSZ;
  localparam logic [31:0] STRIDE = 32'(4 * NDWORDS);

  wr_state_t         state;
  wr_state_t         state_nxt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              advance;
  logic [QW-1:0]     q_head;
  logic [31:0]       head_idx;
  logic [ELEMSZ-1:0] head_data;
  logic [ELEMSZ-1:0] elem_sr;
  logic [31:0]       idx_r;
  logic [31:0]       addr_r;
  logic [BW-1:0]     beat;
  logic              unused_ok;

  assign push = write && !fifo_full;
  assign {head_idx, head_data} = q_head;

  elem_fifo #(
    .WIDTH(QW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({index, data}),
    .dout  (q_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (!avm.avm_m0_waitrequest) begin
          advance = 1'b1;
          if (beat == BW'(NBEATS - 1)) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The element is consumed low halfword first by shifting right one halfword per accepted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elem_sr <= '0;
      idx_r   <= '0;
      addr_r  <= '0;
      beat    <= '0;
    end else if (pop) begin
      elem_sr <= head_data;
      idx_r   <= head_idx;
      addr_r  <= baseaddr + head_idx * STRIDE;
      beat    <= '0;
    end else if (advance) begin
      elem_sr <= elem_sr >> 16;
      addr_r  <= addr_r + 32'd2;
      beat    <= beat + 1'b1;
    end
  end

  assign avm.avm_m0_write      = (state == WRITE);
  assign avm.avm_m0_read       = 1'b0;
  assign avm.avm_m0_address    = addr_r;
  assign avm.avm_m0_writedata  = elem_sr[15:0];
  assign avm.avm_m0_byteenable = 2'b11;

  assign wdone  = (state == DONE);
  assign widx   = idx_r;
  assign iready = !fifo_full;
  assign idle   = fifo_empty && (state == IDLE);

  assign unused_ok = ^{avm.avm_m0_readdata, avm.avm_m0_readdatavalid};

endmodule

// File: tb/tb_writer.sv
// Directed bench for the element writer: single burst, stall, backpressure, wrap and mid-burst reset.
module tb_writer;

  localparam int NDW = 9;
  localparam int ESZ = 32 * NDW;

  logic           clk      = 1'b0;
  logic           reset    = 1'b0;
  logic [31:0]    baseaddr = 32'h1000;
  logic [31:0]    index    = '0;
  logic [ESZ-1:0] data     = '0;
  logic           write    = 1'b0;
  logic           iready;
  logic           wdone;
  logic           idle;
  logic [31:0]    widx;
  int             cyc      = 0;
  int             n_chk    = 0;
  int             n_pass   = 0;

  writer_if avm ();

  writer #(
    .NDWORDS    (NDW),
    .FIFO_DEPTH (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .baseaddr (baseaddr),
    .index    (index),
    .data     (data),
    .write    (write),
    .iready   (iready),
    .wdone    (wdone),
    .widx     (widx),
    .idle     (idle),
    .avm      (avm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] wd;
    logic [1:0]  be;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [31:0] idx;
    int          cyc;
  } done_t;

  beat_t bq[$];
  done_t dq[$];

  // Beats are logged in the cycle they are offered without stall, i.e. accepted at the next edge.
  always @(negedge clk) begin
    if (avm.avm_m0_write && !avm.avm_m0_waitrequest)
      bq.push_back('{avm.avm_m0_address, avm.avm_m0_writedata, avm.avm_m0_byteenable, cyc});
    if (wdone) dq.push_back('{widx, cyc});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [ESZ-1:0] mk_elem(input logic [31:0] d0);
    logic [ESZ-1:0] e;
    e = '0;
    e[31:0] = d0;
    for (int k = 1; k < NDW; k++)
      e[32*k +: 32] = {16'hA000 + 16'(2*k + 1), 16'hA000 + 16'(2*k)};
    return e;
  endfunction

  function automatic logic [15:0] exp_hw(input int j, input logic [31:0] d0);
    if (j == 0) return d0[15:0];
    if (j == 1) return d0[31:16];
    return 16'hA000 + 16'(j);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] idx, input logic [31:0] d0, output int c0);
    int n;
    n     = 0;
    index = idx;
    data  = mk_elem(d0);
    write = 1'b1;
    while (!iready && n < 100) begin
      tick(1);
      n++;
    end
    check("send_iready", iready, 1);
    tick(1);
    c0    = cyc;
    write = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (dq.size() < n && k < 400) begin
      tick(1);
      k++;
    end
    check("wdone_count_reached", dq.size() >= n, 1);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int c0;
    avm.avm_m0_waitrequest   = 1'b0;
    avm.avm_m0_readdata      = '0;
    avm.avm_m0_readdatavalid = 1'b0;

    // Reset values, asserted before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_write", avm.avm_m0_write, 0);
    check("rst_address", avm.avm_m0_address, 0);
    check("rst_writedata", avm.avm_m0_writedata, 0);
    check("rst_wdone", wdone, 0);
    check("rst_widx", widx, 0);
    check("rst_iready", iready, 1);
    check("rst_idle", idle, 1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    tick(2);

    // Single element, no stall.
    bq.delete(); dq.delete();
    send(2, 32'hDEADBEEF, c0);
    wait_done(1);
    tick(2);
    check("single_nbeats", bq.size(), 18);
    for (int j = 0; j < 18; j++) begin
      check($sformatf("single_addr%0d", j), bq[j].addr, 32'h1048 + 32'(2*j));
      check($sformatf("single_data%0d", j), bq[j].wd, exp_hw(j, 32'hDEADBEEF));
      check($sformatf("single_be%0d", j), bq[j].be, 2'b11);
    end
    check("single_beat0_cyc", bq[0].cyc, c0 + 1);
    check("single_beat17_cyc", bq[17].cyc, c0 + 18);
    check("single_ndone", dq.size(), 1);
    check("single_widx", dq[0].idx, 2);
    check("single_wdone_cyc", dq[0].cyc, c0 + 19);
    check("single_idle_after", idle, 1);

    // Three-cycle stall on beat 5.
    bq.delete(); dq.delete();
    send(2, 32'hDEADBEEF, c0);
    wait_cyc(c0 + 6);
    avm.avm_m0_waitrequest = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) avm.avm_m0_waitrequest = 1'b0;
      @(negedge clk);
      check($sformatf("stall_addr_hold%0d", s), avm.avm_m0_address, 32'h1052);
      check($sformatf("stall_data_hold%0d", s), avm.avm_m0_writedata, 16'hA005);
      check($sformatf("stall_write_hold%0d", s), avm.avm_m0_write, 1);
      if (s < 3) tick(1);
    end
    wait_done(1);
    tick(2);
    check("stall_nbeats", bq.size(), 18);
    check("stall_beat4_cyc", bq[4].cyc, c0 + 5);
    check("stall_beat5_cyc", bq[5].cyc, c0 + 9);
    check("stall_beat6_addr", bq[6].addr, 32'h1054);
    check("stall_wdone_cyc", dq[0].cyc, c0 + 22);

    // Backpressure: three requests while the slave stalls.
    bq.delete(); dq.delete();
    avm.avm_m0_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_iready_pre%0d", i), iready, 1);
      index = 32'(i);
      data  = mk_elem(32'hC0DE0000 | 32'(i));
      write = 1'b1;
      tick(1);
    end
    write = 1'b0;
    check("bp_iready_full", iready, 0);
    check("bp_idle_busy", idle, 0);
    tick(4);
    check("bp_iready_still_full", iready, 0);
    check("bp_no_beats_stalled", bq.size(), 0);
    avm.avm_m0_waitrequest = 1'b0;
    wait_done(3);
    tick(2);
    check("bp_ndone", dq.size(), 3);
    check("bp_nbeats", bq.size(), 54);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_widx%0d", i), dq[i].idx, i);
      check($sformatf("bp_first_addr%0d", i), bq[18*i].addr, 32'h1000 + 32'(36*i));
      check($sformatf("bp_first_data%0d", i), bq[18*i].wd, 16'(i));
      check($sformatf("bp_second_data%0d", i), bq[18*i+1].wd, 16'hC0DE);
    end
    check("bp_period01", dq[1].cyc - dq[0].cyc, 20);
    check("bp_period12", dq[2].cyc - dq[1].cyc, 20);
    check("bp_iready_after", iready, 1);
    check("bp_idle_after", idle, 1);

    // Address wrap past 2^32.
    bq.delete(); dq.delete();
    baseaddr = 32'hFFFFFFF0;
    send(0, 32'h12345678, c0);
    wait_done(1);
    tick(2);
    check("wrap_nbeats", bq.size(), 18);
    check("wrap_beat0_addr", bq[0].addr, 32'hFFFFFFF0);
    check("wrap_beat7_addr", bq[7].addr, 32'hFFFFFFFE);
    check("wrap_beat8_addr", bq[8].addr, 32'h00000000);
    check("wrap_beat17_addr", bq[17].addr, 32'h00000012);
    check("wrap_widx", dq[0].idx, 0);
    baseaddr = 32'h1000;

    // Reset in the middle of beat 7.
    bq.delete(); dq.delete();
    send(3, 32'hCAFEF00D, c0);
    wait_cyc(c0 + 8);
    @(negedge clk);
    check("mid_beat7_addr", avm.avm_m0_address, 32'h107A);
    check("mid_beat7_data", avm.avm_m0_writedata, 16'hA007);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_write", avm.avm_m0_write, 0);
    check("mid_rst_address", avm.avm_m0_address, 0);
    check("mid_rst_writedata", avm.avm_m0_writedata, 0);
    check("mid_rst_wdone", wdone, 0);
    check("mid_rst_iready", iready, 1);
    check("mid_rst_idle", idle, 1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    tick(30);
    check("mid_no_wdone", dq.size(), 0);
    check("mid_idle_after", idle, 1);
    check("mid_iready_after", iready, 1);
    bq.delete(); dq.delete();
    send(1, 32'h0BADF00D, c0);
    wait_done(1);
    tick(2);
    check("post_nbeats", bq.size(), 18);
    check("post_beat0_addr", bq[0].addr, 32'h1024);
    check("post_beat0_data", bq[0].wd, 16'hF00D);
    check("post_beat1_data", bq[1].wd, 16'h0BAD);
    check("post_widx", dq[0].idx, 1);
    check("post_wdone_cyc", dq[0].cyc, c0 + 19);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
